// File: rtl/mem_req_arbiter_if.sv
// Bus bundle for mem_req_arbiter: I requester, D requester and memory port.
// slave faces the arbiter; master faces the requesters and memory.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_rdata;
  logic              i_resp_err;

  logic                d_valid;
  logic                d_ready;
  logic [ADDR_W-1:0]   d_addr;
  logic                d_wen;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wmask;
  logic                d_resp_valid;
  logic [DATA_W-1:0]   d_resp_rdata;
  logic                d_resp_err;

  logic                m_valid;
  logic                m_ready;
  logic [ADDR_W-1:0]   m_addr;
  logic                m_wen;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wmask;
  logic                m_resp_valid;
  logic [DATA_W-1:0]   m_resp_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_ready, i_resp_valid,
    output i_resp_rdata, i_resp_err,
    input  d_valid, d_addr, d_wen,
    input  d_wdata, d_wmask,
    output d_ready, d_resp_valid,
    output d_resp_rdata, d_resp_err,
    output m_valid, m_addr, m_wen,
    output m_wdata, m_wmask,
    input  m_ready, m_resp_valid,
    input  m_resp_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_ready, i_resp_valid,
    input  i_resp_rdata, i_resp_err,
    output d_valid, d_addr, d_wen,
    output d_wdata, d_wmask,
    input  d_ready, d_resp_valid,
    input  d_resp_rdata, d_resp_err,
    input  m_valid, m_addr, m_wen,
    input  m_wdata, m_wmask,
    output m_ready, m_resp_valid,
    output m_resp_rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin I/D arbiter for one memory port, one outstanding request.
// Optional perf counters: define MEM_ARB_PERF_EN.
module mem_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] MEM_LAST = 32'h0000_FFFF
) (
  input  logic clk,
  input  logic reset,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_errors,
`endif
  mem_req_arbiter_if.slave bus
);
  localparam int MW = DATA_W / 8;
  localparam logic [ADDR_W-1:0] SPAN =
    MEM_LAST - MEM_BASE;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, ERR
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MW-1:0]     wmask_q;
  logic              m_valid_q;
  logic              i_rv_q, d_rv_q;
  logic              i_err_q, d_err_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic              free;
  logic              gnt_i, gnt_d, grant;
  logic              ok;
  logic [ADDR_W-1:0] sel_addr, off;

  // owner_q/last_q: 1 = D, 0 = I
  assign free  = (state_q == IDLE)
               && !i_rv_q && !d_rv_q;
  assign gnt_i = free && bus.i_valid
               && (!bus.d_valid || last_q);
  assign gnt_d = free && bus.d_valid
               && (!bus.i_valid || !last_q);
  assign grant = gnt_i || gnt_d;

  assign sel_addr = gnt_d ? bus.d_addr
                          : bus.i_addr;
  // wrap-around offset folds both bounds
  assign off = sel_addr - MEM_BASE;
  assign ok  = (sel_addr[1:0] == 2'b00)
             && (off <= SPAN);

  assign bus.i_ready      = gnt_i;
  assign bus.d_ready      = gnt_d;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_addr       = addr_q;
  assign bus.m_wen        = wen_q;
  assign bus.m_wdata      = wdata_q;
  assign bus.m_wmask      = wmask_q;
  assign bus.i_resp_valid = i_rv_q;
  assign bus.i_resp_err   = i_err_q;
  assign bus.i_resp_rdata = i_rdata_q;
  assign bus.d_resp_valid = d_rv_q;
  assign bus.d_resp_err   = d_err_q;
  assign bus.d_resp_rdata = d_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      m_valid_q <= 1'b0;
      i_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      unique case (state_q)
        IDLE: if (grant) begin
          owner_q <= gnt_d;
          last_q  <= gnt_d;
          addr_q  <= sel_addr;
          wen_q   <= gnt_d && bus.d_wen;
          wdata_q <= gnt_d ? bus.d_wdata : '0;
          wmask_q <= gnt_d ? bus.d_wmask : '0;
          if (ok) begin
            state_q   <= ISSUE;
            m_valid_q <= 1'b1;
          end else begin
            state_q <= ERR;
            i_rv_q  <= gnt_i;
            i_err_q <= gnt_i;
            d_rv_q  <= gnt_d;
            d_err_q <= gnt_d;
          end
        end
        ISSUE: if (bus.m_ready) begin
          m_valid_q <= 1'b0;
          state_q   <= WAIT;
        end
        WAIT: if (bus.m_resp_valid) begin
          state_q <= IDLE;
          if (owner_q) begin
            d_rv_q    <= 1'b1;
            d_rdata_q <= bus.m_resp_rdata;
          end else begin
            i_rv_q    <= 1'b1;
            i_rdata_q <= bus.m_resp_rdata;
          end
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_i_grants <= '0;
      perf_d_grants <= '0;
      perf_errors   <= '0;
    end else begin
      if (gnt_i && (perf_i_grants != '1))
        perf_i_grants <= perf_i_grants + 1;
      if (gnt_d && (perf_d_grants != '1))
        perf_d_grants <= perf_d_grants + 1;
      if (grant && !ok && (perf_errors != '1))
        perf_errors <= perf_errors + 1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_resp_in_wait: assert property (
    @(posedge clk) disable iff (reset)
    bus.m_resp_valid |-> state_q == WAIT);
  a_one_resp: assert property (
    @(posedge clk) disable iff (reset)
    !(i_rv_q && d_rv_q));
`endif
endmodule
